// File: rtl/msx_audio_pkg.sv
// msx_audio_pkg: shared types and helpers for the MSX audio mixer.
package msx_audio_pkg;
    typedef enum logic [1:0] {IDLE, ACC, SAT} mix_state_t;

    function automatic int acc_width(input int in_w, input int gain_w, input int channels);
        return in_w + gain_w + 2 + $clog2(channels);
    endfunction

    function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] value, input int width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        return value > hi ? hi : (value < lo ? lo : value);
    endfunction
endpackage

// File: rtl/msx_audio_mixer_if.sv
// msx_audio_mixer_if: sample, gain-config and mixed-output signals of the audio mixer.
interface msx_audio_mixer_if #(
    parameter int CHANNELS = 4,
    parameter int IN_W     = 16,
    parameter int GAIN_W   = 4,
    parameter int OUT_W    = 16
) ();
    localparam int CH_W = $clog2(CHANNELS);
    logic                       sample_stb;
    logic [CHANNELS*IN_W-1:0]   ch_data;
    logic                       cfg_we;
    logic [CH_W-1:0]            cfg_ch;
    logic [GAIN_W-1:0]          cfg_gain;
    logic signed [OUT_W-1:0]    audio_out;
    logic                       out_valid;
    logic                       clip;
    logic                       overrun;
    logic                       busy;

    modport master (
        output sample_stb, ch_data, cfg_we, cfg_ch, cfg_gain,
        input  audio_out, out_valid, clip, overrun, busy
    );
    modport slave (
        input  sample_stb, ch_data, cfg_we, cfg_ch, cfg_gain,
        output audio_out, out_valid, clip, overrun, busy
    );
endinterface

// File: rtl/msx_audio_mac.sv
// msx_audio_mac: one channel's extended sample times gain, floor-shifted to accumulator width.
module msx_audio_mac #(
    parameter int IN_W       = 16,
    parameter int GAIN_W     = 4,
    parameter int GAIN_SHIFT = 3,
    parameter int ACC_W      = 24
) (
    input  logic [IN_W-1:0]          sample,
    input  logic                     is_unsigned,
    input  logic [GAIN_W-1:0]        gain,
    output logic signed [ACC_W-1:0]  term
);
    localparam int PW = IN_W + GAIN_W + 2;
    logic signed [IN_W:0]   ext;
    logic signed [GAIN_W:0] g;
    logic signed [PW-1:0]   prod;
    logic signed [PW-1:0]   shifted;

    assign ext     = {is_unsigned ? 1'b0 : sample[IN_W-1], sample};
    assign g       = {1'b0, gain};
    assign prod    = ext * g;
    assign shifted = prod >>> GAIN_SHIFT;
    assign term    = {{(ACC_W-PW){shifted[PW-1]}}, shifted};
endmodule

// File: rtl/msx_audio_mixer.sv
// msx_audio_mixer: time-multiplexed gain mixer with saturation, one channel per clk21m cycle.
module msx_audio_mixer
    import msx_audio_pkg::*;
#(
    parameter int                  CHANNELS      = 4,
    parameter int                  IN_W          = 16,
    parameter int                  GAIN_W        = 4,
    parameter int                  GAIN_SHIFT    = 3,
    parameter int                  OUT_W         = 16,
    parameter logic [CHANNELS-1:0] UNSIGNED_MASK = '0
) (
    input logic                clk21m,
    input logic                reset,
    msx_audio_mixer_if.slave   bus
);
    localparam int CH_W  = $clog2(CHANNELS);
    localparam int ACC_W = acc_width(IN_W, GAIN_W, CHANNELS);
    localparam logic [GAIN_W-1:0] UNITY = GAIN_W'(1 << GAIN_SHIFT);

    mix_state_t               state;
    logic [GAIN_W-1:0]        gain      [CHANNELS];
    logic [GAIN_W-1:0]        snap_gain [CHANNELS];
    logic [IN_W-1:0]          snap_data [CHANNELS];
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  term;
    logic [CH_W-1:0]          idx;
    logic signed [63:0]       acc64;
    logic signed [63:0]       sat_val;

    msx_audio_mac #(
        .IN_W(IN_W), .GAIN_W(GAIN_W), .GAIN_SHIFT(GAIN_SHIFT), .ACC_W(ACC_W)
    ) mac (
        .sample(snap_data[idx]),
        .is_unsigned(UNSIGNED_MASK[idx]),
        .gain(snap_gain[idx]),
        .term(term)
    );

    assign acc64    = {{(64-ACC_W){acc[ACC_W-1]}}, acc};
    assign sat_val  = sat_clamp(acc64, OUT_W);
    assign bus.busy = state != IDLE;

    always_ff @(posedge clk21m or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            acc           <= '0;
            idx           <= '0;
            bus.audio_out <= '0;
            bus.out_valid <= 1'b0;
            bus.clip      <= 1'b0;
            bus.overrun   <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                gain[i]      <= UNITY;
                snap_gain[i] <= '0;
                snap_data[i] <= '0;
            end
        end else begin
            bus.out_valid <= 1'b0;
            bus.clip      <= 1'b0;
            bus.overrun   <= bus.sample_stb && state != IDLE;
            // The snapshot below reads the pre-edge gain, so a same-cycle write lands next sample.
            if (bus.cfg_we && int'(bus.cfg_ch) < CHANNELS)
                gain[bus.cfg_ch] <= bus.cfg_gain;
            case (state)
                IDLE: if (bus.sample_stb) begin
                    for (int i = 0; i < CHANNELS; i++) begin
                        snap_data[i] <= bus.ch_data[i*IN_W +: IN_W];
                        snap_gain[i] <= gain[i];
                    end
                    acc   <= '0;
                    idx   <= '0;
                    state <= ACC;
                end
                ACC: begin
                    acc <= acc + term;
                    idx <= idx + 1'b1;
                    if (idx == CH_W'(CHANNELS - 1))
                        state <= SAT;
                end
                SAT: begin
                    bus.audio_out <= sat_val[OUT_W-1:0];
                    bus.clip      <= sat_val != acc64;
                    bus.out_valid <= 1'b1;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_msx_audio_mixer.sv
// tb_msx_audio_mixer: directed vectors for the audio mixer, channel 3 configured unsigned.
module tb_msx_audio_mixer;
    logic clk21m = 1'b0;
    logic reset  = 1'b1;
    int   vectors = 0;
    int   errors  = 0;

    always #5 clk21m = ~clk21m;

    msx_audio_mixer_if #(.CHANNELS(4), .IN_W(16), .GAIN_W(4), .OUT_W(16)) bus ();

    msx_audio_mixer #(
        .CHANNELS(4), .IN_W(16), .GAIN_W(4), .GAIN_SHIFT(3), .OUT_W(16), .UNSIGNED_MASK(4'b1000)
    ) dut (
        .clk21m(clk21m),
        .reset(reset),
        .bus(bus)
    );

    task automatic set_ch(input logic [15:0] c3, input logic [15:0] c2, input logic [15:0] c1, input logic [15:0] c0);
        bus.ch_data = {c3, c2, c1, c0};
    endtask

    task automatic set_gain(input logic [1:0] ch, input logic [3:0] g);
        @(negedge clk21m);
        bus.cfg_we   = 1'b1;
        bus.cfg_ch   = ch;
        bus.cfg_gain = g;
        @(negedge clk21m);
        bus.cfg_we   = 1'b0;
    endtask

    task automatic run_mix(input bit wr, input logic [1:0] wch, input logic [3:0] wg,
                           output logic [15:0] val, output logic clp, output int lat);
        @(negedge clk21m);
        bus.sample_stb = 1'b1;
        bus.cfg_we     = wr;
        bus.cfg_ch     = wch;
        bus.cfg_gain   = wg;
        @(negedge clk21m);
        bus.sample_stb = 1'b0;
        bus.cfg_we     = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(negedge clk21m);
            lat++;
        end
        val = bus.audio_out;
        clp = bus.clip;
    endtask

    task automatic test_reset();
        bus.sample_stb = 1'b0;
        bus.cfg_we     = 1'b0;
        bus.cfg_ch     = '0;
        bus.cfg_gain   = '0;
        bus.ch_data    = '0;
        repeat (2) @(negedge clk21m);
        vectors++; if (bus.audio_out !== 16'h0) begin errors++; $display("FAIL reset audio_out got %h want 0000", bus.audio_out); end
        vectors++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid got %b want 0", bus.out_valid); end
        vectors++; if (bus.clip !== 1'b0) begin errors++; $display("FAIL reset clip got %b want 0", bus.clip); end
        vectors++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL reset overrun got %b want 0", bus.overrun); end
        vectors++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset busy got %b want 0", bus.busy); end
        reset = 1'b0;
    endtask

    task automatic test_unity_mix();
        logic [15:0] v; logic c; int l;
        set_ch(16'd300, 16'd0, -16'sd200, 16'd1000);
        run_mix(0, 2'd0, 4'd0, v, c, l);
        vectors++; if (l !== 5) begin errors++; $display("FAIL unity latency got %0d want 5", l); end
        vectors++; if (v !== 16'd1100) begin errors++; $display("FAIL unity audio_out got %0d want 1100", $signed(v)); end
        vectors++; if (c !== 1'b0) begin errors++; $display("FAIL unity clip got %b want 0", c); end
        @(negedge clk21m);
        vectors++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL unity out_valid pulse width got %b want 0", bus.out_valid); end
        vectors++; if (bus.audio_out !== 16'd1100) begin errors++; $display("FAIL unity hold got %0d want 1100", $signed(bus.audio_out)); end
    endtask

    task automatic test_unsigned();
        logic [15:0] v; logic c; int l;
        set_ch(16'hFFFF, 16'd0, 16'd0, 16'd0);
        run_mix(0, 2'd0, 4'd0, v, c, l);
        vectors++; if (v !== 16'h7FFF) begin errors++; $display("FAIL unsigned ch3 got %h want 7fff", v); end
        vectors++; if (c !== 1'b1) begin errors++; $display("FAIL unsigned clip got %b want 1", c); end
    endtask

    task automatic test_saturation();
        logic [15:0] v; logic c; int l;
        set_ch(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
        run_mix(0, 2'd0, 4'd0, v, c, l);
        vectors++; if (v !== 16'h7FFF) begin errors++; $display("FAIL sat_pos got %h want 7fff", v); end
        vectors++; if (c !== 1'b1) begin errors++; $display("FAIL sat_pos clip got %b want 1", c); end
        set_ch(16'h8000, 16'h8000, 16'h8000, 16'h8000);
        run_mix(0, 2'd0, 4'd0, v, c, l);
        vectors++; if (v !== 16'h8000) begin errors++; $display("FAIL sat_neg got %h want 8000", v); end
        vectors++; if (c !== 1'b1) begin errors++; $display("FAIL sat_neg clip got %b want 1", c); end
    endtask

    task automatic test_gain_sweep();
        logic [15:0] v; logic c; int l;
        logic [3:0]  g_tab [3] = '{4'd4, 4'd0, 4'd15};
        logic [15:0] e_tab [3] = '{16'd500, 16'd0, 16'd1875};
        set_ch(16'd0, 16'd0, 16'd0, 16'd1000);
        for (int i = 0; i < 3; i++) begin
            set_gain(2'd0, g_tab[i]);
            run_mix(0, 2'd0, 4'd0, v, c, l);
            vectors++; if (v !== e_tab[i]) begin errors++; $display("FAIL gain %0d got %0d want %0d", g_tab[i], $signed(v), e_tab[i]); end
        end
        set_ch(16'd0, 16'd0, 16'd0, -16'sd3);
        set_gain(2'd0, 4'd1);
        run_mix(0, 2'd0, 4'd0, v, c, l);
        vectors++; if (v !== 16'hFFFF) begin errors++; $display("FAIL floor -3*1/8 got %0d want -1", $signed(v)); end
        set_gain(2'd0, 4'd8);
    endtask

    task automatic test_overrun();
        int ovr_n = 0, ovr_at = -1, val_n = 0, val_at = -1;
        set_ch(16'd300, 16'd0, -16'sd200, 16'd1000);
        for (int c = 0; c < 16; c++) begin
            @(negedge clk21m);
            if (bus.overrun) begin ovr_n++; ovr_at = c; end
            if (bus.out_valid) begin val_n++; if (val_at < 0) val_at = c; end
            bus.sample_stb = (c == 0 || c == 3 || c == 6);
        end
        vectors++; if (ovr_n !== 1) begin errors++; $display("FAIL overrun count got %0d want 1", ovr_n); end
        vectors++; if (ovr_at !== 4) begin errors++; $display("FAIL overrun cycle got %0d want 4", ovr_at); end
        vectors++; if (val_n !== 2) begin errors++; $display("FAIL overrun out_valid count got %0d want 2", val_n); end
        vectors++; if (val_at !== 6) begin errors++; $display("FAIL overrun first out_valid got %0d want 6", val_at); end
        vectors++; if (bus.audio_out !== 16'd1100) begin errors++; $display("FAIL overrun audio_out got %0d want 1100", $signed(bus.audio_out)); end
    endtask

    task automatic test_same_cycle();
        logic [15:0] v; logic c; int l;
        set_ch(16'd0, 16'd0, 16'd0, 16'd1000);
        run_mix(1, 2'd0, 4'd0, v, c, l);
        vectors++; if (v !== 16'd1000) begin errors++; $display("FAIL same_cycle first got %0d want 1000", $signed(v)); end
        run_mix(0, 2'd0, 4'd0, v, c, l);
        vectors++; if (v !== 16'd0) begin errors++; $display("FAIL same_cycle second got %0d want 0", $signed(v)); end
        set_gain(2'd0, 4'd8);
    endtask

    task automatic test_reset_abort();
        logic [15:0] v; logic c; int l; int val_n = 0;
        set_ch(16'd0, 16'd0, 16'd0, 16'd1000);
        set_gain(2'd0, 4'd3);
        run_mix(0, 2'd0, 4'd0, v, c, l);
        vectors++; if (v !== 16'd375) begin errors++; $display("FAIL abort pre gain3 got %0d want 375", $signed(v)); end
        @(negedge clk21m);
        bus.sample_stb = 1'b1;
        @(negedge clk21m);
        bus.sample_stb = 1'b0;
        @(negedge clk21m);
        reset = 1'b1;
        #1;
        vectors++; if (bus.audio_out !== 16'h0) begin errors++; $display("FAIL abort audio_out got %h want 0000", bus.audio_out); end
        vectors++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort busy got %b want 0", bus.busy); end
        @(negedge clk21m);
        reset = 1'b0;
        repeat (10) begin
            @(negedge clk21m);
            if (bus.out_valid) val_n++;
        end
        vectors++; if (val_n !== 0) begin errors++; $display("FAIL abort out_valid count got %0d want 0", val_n); end
        run_mix(0, 2'd0, 4'd0, v, c, l);
        vectors++; if (l !== 5) begin errors++; $display("FAIL abort post latency got %0d want 5", l); end
        vectors++; if (v !== 16'd1000) begin errors++; $display("FAIL abort post gain unity got %0d want 1000", $signed(v)); end
    endtask

    initial begin
        test_reset();
        test_unity_mix();
        test_unsigned();
        test_saturation();
        test_gain_sweep();
        test_overrun();
        test_same_cycle();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
